// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit.
//  - opcode constants (full-width and prefix forms)
//  - ALU function-select codes
//  - ControlWord field offsets and the NOP word
//  - FSM state encoding
//  - pack_cw(): assembles a ControlWord and keeps XZR from being written
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;

    // ControlWord = {SA,SB,DA,RegWrite,MemWrite,FS,Bsel,EN_Mem,EN_ALU}
    localparam int CW_SA_LSB  = 20;
    localparam int CW_SB_LSB  = 15;
    localparam int CW_DA_LSB  = 10;
    localparam int CW_RW_BIT  = 9;
    localparam int CW_MW_BIT  = 8;
    localparam int CW_FS_LSB  = 3;
    localparam int CW_BS_BIT  = 2;
    localparam int CW_MEM_BIT = 1;
    localparam int CW_ALU_BIT = 0;

    localparam logic [24:0] NOP_CW = 25'b0;
    localparam logic [4:0]  XZR    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    // Assemble a ControlWord; a write to X31 is suppressed because XZR is hard zero.
    function automatic logic [24:0] pack_cw(
        input logic [4:0] sa,
        input logic [4:0] sb,
        input logic [4:0] da,
        input logic       rw,
        input logic       mw,
        input logic [4:0] fs,
        input logic       bsel,
        input logic       en_mem,
        input logic       en_alu
    );
        logic rw_eff;
        rw_eff = rw & (da != XZR);
        return {sa, sb, da, rw_eff, mw, fs, bsel, en_mem, en_alu};
    endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 instruction decoder.
// Ports:
//  ir_i          in  32  instruction word
//  cw_o          out 25  datapath ControlWord
//  constant_o    out 64  immediate for the datapath B input
//  is_b_o        out 1   unconditional branch
//  is_cbz_o      out 1   compare-and-branch-if-zero
//  is_halt_o     out 1   all-zero word
//  is_illegal_o  out 1   opcode not recognised
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [24:0] cw_o,
    output logic [63:0] constant_o,
    output logic        is_b_o,
    output logic        is_cbz_o,
    output logic        is_halt_o,
    output logic        is_illegal_o
);

    logic [10:0] op_s;
    logic [4:0]  rd_s;
    logic [4:0]  rn_s;
    logic [4:0]  rm_s;
    logic [4:0]  fs_r_s;

    assign op_s = ir_i[31:21];
    assign rd_s = ir_i[4:0];
    assign rn_s = ir_i[9:5];
    assign rm_s = ir_i[20:16];

    // ALU function for the register-register group
    always_comb begin
        case (op_s)
            OP_ADD:  fs_r_s = FS_ADD;
            OP_SUB:  fs_r_s = FS_SUB;
            OP_AND:  fs_r_s = FS_AND;
            OP_ORR:  fs_r_s = FS_ORR;
            default: fs_r_s = FS_ADD;
        endcase
    end

    // Main decode; the all-zero HALT word is tested before any opcode match
    always_comb begin
        cw_o         = NOP_CW;
        constant_o   = 64'd0;
        is_b_o       = 1'b0;
        is_cbz_o     = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        if (ir_i == 32'h0000_0000) begin
            is_halt_o = 1'b1;
        end else if (op_s == OP_ADD || op_s == OP_SUB || op_s == OP_AND || op_s == OP_ORR) begin
            cw_o = pack_cw(rn_s, rm_s, rd_s, 1'b1, 1'b0, fs_r_s, 1'b0, 1'b0, 1'b1);
        end else if (ir_i[31:22] == OP_ADDI || ir_i[31:22] == OP_SUBI) begin
            cw_o = pack_cw(rn_s, 5'd0, rd_s, 1'b1, 1'b0,
                           (ir_i[31:22] == OP_SUBI) ? FS_SUB : FS_ADD, 1'b1, 1'b0, 1'b1);
            constant_o = {52'd0, ir_i[21:10]};
        end else if (op_s == OP_LDUR) begin
            cw_o = pack_cw(rn_s, 5'd0, rd_s, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b1, 1'b0);
            constant_o = {{55{ir_i[20]}}, ir_i[20:12]};
        end else if (op_s == OP_STUR) begin
            // Rt travels on the SB bus as store data
            cw_o = pack_cw(rn_s, rd_s, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b1, 1'b1, 1'b0);
            constant_o = {{55{ir_i[20]}}, ir_i[20:12]};
        end else if (ir_i[31:24] == OP_CBZ) begin
            // Rt + 0 through the ALU so the datapath raises Z when Rt is zero
            cw_o = pack_cw(rd_s, XZR, XZR, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
            is_cbz_o = 1'b1;
        end else if (ir_i[31:26] == OP_B) begin
            is_b_o = 1'b1;
        end else begin
            is_illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: fetches from a combinational ROM,
// presents a registered ControlWord/constant for one S_EXEC cycle per
// instruction and sequences the PC (including B and CBZ).
// Ports:
//  clock        in  1     rising-edge clock
//  reset        in  1     asynchronous, active-low
//  run          in  1     1 = keep executing, 0 = stop after current instruction
//  instr_data   in  32    instruction at instr_addr
//  status       in  4     {V,C,N,Z} from the datapath
//  instr_addr   out PC_W  fetch byte address (= pc)
//  ControlWord  out 25    datapath control
//  constant     out 64    datapath immediate
//  pc           out PC_W  current PC
//  halted       out 1     in S_HALT
//  illegal      out 1     sticky undecodable-opcode flag
module legv8_control_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          PC_W     = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [31:0]     instr_data,
    input  logic [3:0]      status,
    output logic [PC_W-1:0] instr_addr,
    output logic [24:0]     ControlWord,
    output logic [63:0]     constant,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic [31:0]     ir_q, ir_d;
    logic [24:0]     cw_q, cw_d;
    logic [63:0]     const_q, const_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;

    logic [31:0]     dec_ir_s;
    logic [24:0]     dec_cw_s;
    logic [63:0]     dec_const_s;
    logic            dec_b_s, dec_cbz_s, dec_halt_s, dec_illegal_s;
    logic [PC_W-1:0] b_off_s, cbz_off_s;
    logic            unused_status_s;

    assign unused_status_s = ^status[3:1];

    // In S_FETCH decode the incoming word so ControlWord can be registered
    // on the same edge that captures IR; in S_EXEC decode the held IR.
    assign dec_ir_s = (state_q == S_FETCH) ? instr_data : ir_q;

    legv8_decoder u_dec (
        .ir_i         (dec_ir_s),
        .cw_o         (dec_cw_s),
        .constant_o   (dec_const_s),
        .is_b_o       (dec_b_s),
        .is_cbz_o     (dec_cbz_s),
        .is_halt_o    (dec_halt_s),
        .is_illegal_o (dec_illegal_s)
    );

    assign b_off_s   = {{(PC_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    assign cbz_off_s = {{(PC_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};

    // Next-state, PC sequencing and output-register loads
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ipc_d     = ipc_q;
        ir_d      = ir_q;
        cw_d      = NOP_CW;
        const_d   = 64'd0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_d    = instr_data;
                ipc_d   = pc_q;
                cw_d    = dec_cw_s;
                const_d = dec_const_s;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec_b_s) begin
                    pc_d = ipc_q + b_off_s;
                end else if (dec_cbz_s && status[0]) begin
                    pc_d = ipc_q + cbz_off_s;
                end else begin
                    pc_d = pc_q + {{(PC_W-3){1'b0}}, 3'd4};
                end
                if (dec_halt_s || dec_illegal_s) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = illegal_q | dec_illegal_s;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC[PC_W-1:0];
            ipc_q     <= RESET_PC[PC_W-1:0];
            ir_q      <= 32'd0;
            cw_q      <= NOP_CW;
            const_q   <= 64'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ipc_q     <= ipc_d;
            ir_q      <= ir_d;
            cw_q      <= cw_d;
            const_q   <= const_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_addr  = pc_q;
    assign pc          = pc_q;
    assign ControlWord = cw_q;
    assign constant    = const_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed self-checking bench for legv8_control_unit with a small ROM model.
module tb_legv8_control_unit;

    logic        clock;
    logic        reset;
    logic        run;
    logic [31:0] instr_data;
    logic [3:0]  status;
    logic [63:0] instr_addr;
    logic [24:0] ControlWord;
    logic [63:0] constant;
    logic [63:0] pc;
    logic        halted;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [0:63];

    localparam logic [31:0] I_ADDI  = 32'h910013E5; // ADDI X5,XZR,#4
    localparam logic [31:0] I_SUB   = 32'hCB0C01FE; // SUB X30,X15,X12
    localparam logic [31:0] I_ADD31 = 32'h8B02003F; // ADD X31,X1,X2
    localparam logic [31:0] I_STUR  = 32'hF8000022; // STUR X2,[X1,#0]
    localparam logic [31:0] I_LDUR  = 32'hF84002DC; // LDUR X28,[X22,#0]
    localparam logic [31:0] I_LDURN = 32'hF85F8041; // LDUR X1,[X2,#-8]
    localparam logic [31:0] I_CBZ   = 32'hB4000063; // CBZ X3,#+3
    localparam logic [31:0] I_B     = 32'h17FFFFFE; // B #-2

    localparam logic [24:0] CW_ADDI  = 25'b1111100000001011001000101;
    localparam logic [24:0] CW_SUB   = 25'b0111101100111101001010001;
    localparam logic [24:0] CW_ADD31 = 25'b0000100010111110001000001;
    localparam logic [24:0] CW_STUR  = 25'b0000100010000000101000110;
    localparam logic [24:0] CW_LDUR  = 25'b1011000000111001001000110;
    localparam logic [24:0] CW_LDURN = 25'b0001000000000011001000110;
    localparam logic [24:0] CW_CBZ   = 25'b0001111111111110001000101;

    assign instr_data = (instr_addr < 64'd256) ? rom[instr_addr[7:2]] : 32'h0000_0000;

    legv8_control_unit dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .instr_data  (instr_data),
        .status      (status),
        .instr_addr  (instr_addr),
        .ControlWord (ControlWord),
        .constant    (constant),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
    endtask

    // Hold reset over two edges, release on a falling edge with run=1.
    task automatic apply_reset();
        run   = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = I_ADDI;
        run    = 1'b1;
        status = 4'b0000;
        reset  = 1'b0;
        #3;
        checks++; if (instr_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", instr_addr, 64'd0); end
        checks++; if (ControlWord !== 25'd0) begin errors++; $display("FAIL reset_cw got=%b exp=%b", ControlWord, 25'd0); end
        checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", halted, illegal); end
        checks++; if (constant !== 64'd0) begin errors++; $display("FAIL reset_const got=%h exp=0", constant); end
        @(negedge clock);
        reset = 1'b1;
        cycles(1); // FETCH
        checks++; if (ControlWord !== 25'd0) begin errors++; $display("FAIL fetch_cw_nop got=%b exp=0", ControlWord); end
        cycles(1); // EXEC
        checks++; if (ControlWord !== CW_ADDI) begin errors++; $display("FAIL exec_at_cycle2 got=%b exp=%b", ControlWord, CW_ADDI); end
    endtask

    task automatic test_addi();
        clear_rom();
        rom[0] = I_ADDI;
        apply_reset();
        cycles(2);
        checks++; if (ControlWord !== CW_ADDI) begin errors++; $display("FAIL addi_cw got=%b exp=%b", ControlWord, CW_ADDI); end
        checks++; if (constant !== 64'd4) begin errors++; $display("FAIL addi_const got=%h exp=%h", constant, 64'd4); end
        checks++; if (pc !== 64'd0) begin errors++; $display("FAIL addi_pc_exec got=%h exp=0", pc); end
        cycles(1);
        checks++; if (pc !== 64'd4) begin errors++; $display("FAIL addi_pc_next got=%h exp=4", pc); end
        checks++; if (ControlWord !== 25'd0) begin errors++; $display("FAIL addi_cw_one_cycle got=%b exp=0", ControlWord); end
    endtask

    task automatic test_rtype();
        clear_rom();
        rom[0] = I_SUB;
        rom[1] = I_ADD31;
        apply_reset();
        cycles(2);
        checks++; if (ControlWord !== CW_SUB) begin errors++; $display("FAIL sub_cw got=%b exp=%b", ControlWord, CW_SUB); end
        cycles(2);
        checks++; if (ControlWord !== CW_ADD31) begin errors++; $display("FAIL add_xzr_cw got=%b exp=%b", ControlWord, CW_ADD31); end
        checks++; if (pc !== 64'd4) begin errors++; $display("FAIL rtype_pc got=%h exp=4", pc); end
    endtask

    task automatic test_mem();
        clear_rom();
        rom[0] = I_STUR;
        rom[1] = I_LDUR;
        rom[2] = I_LDURN;
        apply_reset();
        cycles(2);
        checks++; if (ControlWord !== CW_STUR) begin errors++; $display("FAIL stur_cw got=%b exp=%b", ControlWord, CW_STUR); end
        cycles(2);
        checks++; if (ControlWord !== CW_LDUR) begin errors++; $display("FAIL ldur_cw got=%b exp=%b", ControlWord, CW_LDUR); end
        cycles(2);
        checks++; if (ControlWord !== CW_LDURN) begin errors++; $display("FAIL ldur_neg_cw got=%b exp=%b", ControlWord, CW_LDURN); end
        checks++; if (constant !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL ldur_neg_const got=%h exp=fffffffffffffff8", constant); end
    endtask

    task automatic load_branch_prog();
        clear_rom();
        rom[0] = I_ADDI;
        rom[1] = I_ADDI;
        rom[2] = I_CBZ;
        rom[3] = I_ADDI;
        rom[4] = I_B;
        rom[5] = 32'h0000_0000;
    endtask

    task automatic test_branch();
        load_branch_prog();
        status = 4'b0001;
        apply_reset();
        cycles(6); // EXEC of CBZ at pc=8
        checks++; if (ControlWord !== CW_CBZ) begin errors++; $display("FAIL cbz_cw got=%b exp=%b", ControlWord, CW_CBZ); end
        checks++; if (constant !== 64'd0) begin errors++; $display("FAIL cbz_const got=%h exp=0", constant); end
        cycles(1);
        checks++; if (pc !== 64'd20) begin errors++; $display("FAIL cbz_taken_pc got=%0d exp=20", pc); end
        cycles(2);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL cbz_then_halt got=%b exp=1", halted); end

        load_branch_prog();
        status = 4'b0000;
        apply_reset();
        cycles(7);
        checks++; if (pc !== 64'd12) begin errors++; $display("FAIL cbz_not_taken_pc got=%0d exp=12", pc); end
        cycles(3); // EXEC of B at pc=16
        checks++; if (ControlWord !== 25'd0 || pc !== 64'd16) begin errors++; $display("FAIL b_exec got cw=%b pc=%0d exp cw=0 pc=16", ControlWord, pc); end
        cycles(1);
        checks++; if (pc !== 64'd8) begin errors++; $display("FAIL b_back_pc got=%0d exp=8", pc); end
    endtask

    task automatic test_halt();
        clear_rom();
        apply_reset();
        cycles(3);
        checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL halt_flags got=%b%b exp=10", halted, illegal); end
        cycles(6);
        checks++; if (halted !== 1'b1 || ControlWord !== 25'd0) begin errors++; $display("FAIL halt_held got h=%b cw=%b exp h=1 cw=0", halted, ControlWord); end
    endtask

    task automatic test_illegal();
        clear_rom();
        rom[0] = 32'hFFFF_FFFF;
        apply_reset();
        cycles(2);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL illegal_early_halt got=%b exp=0", halted); end
        cycles(1);
        checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL illegal_flags got=%b%b exp=11", illegal, halted); end
        cycles(4);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b exp=1", illegal); end
    endtask

    task automatic test_run_drop();
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = I_ADDI;
        apply_reset();
        cycles(2); // EXEC at pc=0
        run = 1'b0;
        cycles(1);
        checks++; if (pc !== 64'd4) begin errors++; $display("FAIL rundrop_pc got=%0d exp=4", pc); end
        cycles(4);
        checks++; if (pc !== 64'd4 || ControlWord !== 25'd0) begin errors++; $display("FAIL rundrop_idle got pc=%0d cw=%b exp pc=4 cw=0", pc, ControlWord); end
        run = 1'b1;
        cycles(2);
        checks++; if (ControlWord !== CW_ADDI) begin errors++; $display("FAIL rundrop_resume got=%b exp=%b", ControlWord, CW_ADDI); end
    endtask

    task automatic test_async_reset();
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = I_ADDI;
        apply_reset();
        cycles(4); // EXEC at pc=4
        checks++; if (ControlWord !== CW_ADDI || pc !== 64'd4) begin errors++; $display("FAIL areset_pre got cw=%b pc=%0d exp cw=%b pc=4", ControlWord, pc, CW_ADDI); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (ControlWord !== 25'd0 || constant !== 64'd0) begin errors++; $display("FAIL areset_cw got cw=%b k=%h exp 0", ControlWord, constant); end
        checks++; if (pc !== 64'd0) begin errors++; $display("FAIL areset_pc got=%0d exp=0", pc); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        run    = 1'b0;
        status = 4'b0000;
        test_reset();
        test_addi();
        test_rtype();
        test_mem();
        test_branch();
        test_halt();
        test_illegal();
        test_run_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
